// File: rtl/operand_fetch_stage.sv
// ID->EX operand stage: reads the register file, bypasses EX/MEM/WB results, and registers the operands into the ID/EX pipeline register.
// Latency: 1 cycle from id accept to ex_valid. A load followed by a dependent instruction costs exactly one bubble.
// Backpressure: id_ready = (ID/EX empty or EX ready) and no load-use hazard. While EX is stalled, all ID/EX fields hold.
module operand_fetch_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_is_load,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic [DATA_W-1:0] ex_res,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_wa,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [ADDR_W-1:0] ex_dest,
  output logic              ex_is_load,
  output logic [CNT_W-1:0]  stall_cnt
);

  // ID/EX pipeline register state and its next-state values
  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_op_a_q, ex_op_a_d;
  logic [DATA_W-1:0] ex_op_b_q, ex_op_b_d;
  logic [ADDR_W-1:0] ex_dest_q, ex_dest_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              ex_fwd_en;
  logic              hz;
  logic              adv;
  logic [DATA_W-1:0] op_a_sel;
  logic [DATA_W-1:0] op_b_sel;

  // Bypass mux for one source, youngest producer first. The WB leg is needed
  // because the register file returns the pre-write value on a same-cycle write.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [ADDR_W-1:0] s,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_en,
    input logic [ADDR_W-1:0] ex_d,
    input logic [DATA_W-1:0] ex_v,
    input logic              m_we,
    input logic [ADDR_W-1:0] m_wa,
    input logic [DATA_W-1:0] m_wd,
    input logic              w_we,
    input logic [ADDR_W-1:0] w_wa,
    input logic [DATA_W-1:0] w_wd
  );
    logic [DATA_W-1:0] v;
    if (s == '0)                    v = '0;
    else if (ex_en && ex_d == s)    v = ex_v;
    else if (m_we && m_wa == s)     v = m_wd;
    else if (w_we && w_wa == s)     v = w_wd;
    else                            v = rf_val;
    return v;
  endfunction

  assign ra1 = id_rs;
  assign ra2 = id_rt;

  // A load in EX has no result yet, so it must never forward from ex_res
  assign ex_fwd_en = ex_valid_q && !ex_is_load_q;

  // Operand selection for both sources
  always_comb begin
    op_a_sel = pick_operand(id_rs, rd1, ex_fwd_en, ex_dest_q, ex_res,
                            mem_we, mem_wa, mem_wd, wb_we, wb_wa, wb_wd);
    op_b_sel = pick_operand(id_rt, rd2, ex_fwd_en, ex_dest_q, ex_res,
                            mem_we, mem_wa, mem_wd, wb_we, wb_wa, wb_wd);
  end

  // Load-use hazard: only sources the instruction actually reads can stall
  assign hz = id_valid && ex_valid_q && ex_is_load_q && (ex_dest_q != '0) &&
              ((id_uses_rs && id_rs == ex_dest_q) ||
               (id_uses_rt && id_rt == ex_dest_q));

  assign adv      = !ex_valid_q || ex_ready;
  assign id_ready = adv && !hz;

  // Next-state for the ID/EX register; flush beats everything, and a held
  // entry keeps its operands because they were fully bypassed at capture
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_op_a_d    = ex_op_a_q;
    ex_op_b_d    = ex_op_b_q;
    ex_dest_d    = ex_dest_q;
    ex_is_load_d = ex_is_load_q;
    stall_cnt_d  = stall_cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (adv) begin
      if (hz) begin
        ex_valid_d = 1'b0;
        if (stall_cnt_q != {CNT_W{1'b1}}) begin
          stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else if (id_valid) begin
        ex_valid_d   = 1'b1;
        ex_op_a_d    = op_a_sel;
        ex_op_b_d    = op_b_sel;
        ex_dest_d    = id_dest;
        ex_is_load_d = id_is_load;
      end else begin
        ex_valid_d = 1'b0;
      end
    end
  end

  // ID/EX register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_op_a_q    <= '0;
      ex_op_b_q    <= '0;
      ex_dest_q    <= '0;
      ex_is_load_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op_a_q    <= ex_op_a_d;
      ex_op_b_q    <= ex_op_b_d;
      ex_dest_q    <= ex_dest_d;
      ex_is_load_q <= ex_is_load_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_op_a    = ex_op_a_q;
  assign ex_op_b    = ex_op_b_q;
  assign ex_dest    = ex_dest_q;
  assign ex_is_load = ex_is_load_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
